// File: rtl/fetch_stage.sv
// F-stage of the 5-stage MIPS pipeline: PC register, instruction-memory handshake and IF/ID register.
// Define FETCH_ADEL_EN to add the fetch address-error (AdEL) check before a request is issued.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] npc,
    input  logic        d_clear,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic        d_valid,
    output logic        d_exc,
    output logic [4:0]  d_exccode
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] buf_instr;
    logic [31:0] redir_pc;
    logic        redir_pend;
    logic        kill_pend;

    logic        addr_bad;
    logic        handoff;
    logic        bubble;
    logic        capture;
    logic        hold_word;
    logic        kill;
    logic [31:0] handoff_instr;
    logic [31:0] pc_next;

`ifdef FETCH_ADEL_EN
    assign addr_bad = (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFF);
`else
    assign addr_bad = 1'b0;
`endif

    assign im_addr = pc;
    assign kill    = kill_pend | d_clear;
    assign capture = ~stall & ~handoff;
    // A live redirect from D beats one captured while the slot was still in flight.
    assign pc_next = branch ? npc : (redir_pend ? redir_pc : pc + 32'd4);

    always_comb begin
        state_next    = state;
        im_req        = 1'b0;
        handoff       = 1'b0;
        bubble        = 1'b0;
        hold_word     = 1'b0;
        handoff_instr = im_rdata;
        case (state)
            BOOT: state_next = FETCH;
            FETCH: begin
                im_req = ~addr_bad;
                if (addr_bad) begin
                    handoff       = ~stall;
                    handoff_instr = 32'd0;
                end else if (im_ready) begin
                    if (stall) begin
                        hold_word  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        handoff = 1'b1;
                    end
                end else begin
                    bubble = ~stall;
                end
            end
            HOLD: begin
                handoff_instr = buf_instr;
                if (!stall) begin
                    handoff    = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            buf_instr  <= 32'd0;
            redir_pc   <= 32'd0;
            redir_pend <= 1'b0;
            kill_pend  <= 1'b0;
        end else begin
            state <= state_next;
            if (hold_word)
                buf_instr <= im_rdata;
            if (handoff) begin
                pc         <= pc_next;
                redir_pend <= 1'b0;
                kill_pend  <= 1'b0;
            end else if (capture) begin
                // The in-flight word is the delay slot, so the redirect waits for its handoff.
                if (branch) begin
                    redir_pend <= 1'b1;
                    redir_pc   <= npc;
                end
                if (d_clear)
                    kill_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_instr <= 32'd0;
            d_pc    <= RESET_PC;
            d_valid <= 1'b0;
        end else if (handoff) begin
            d_pc    <= pc;
            d_instr <= kill ? 32'd0 : handoff_instr;
            d_valid <= ~kill;
        end else if (bubble) begin
            d_instr <= 32'd0;
            d_valid <= 1'b0;
        end
    end

`ifdef FETCH_ADEL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_exc     <= 1'b0;
            d_exccode <= 5'd0;
        end else if (handoff) begin
            d_exc     <= addr_bad & ~kill;
            d_exccode <= (addr_bad & ~kill) ? 5'd4 : 5'd0;
        end else if (bubble) begin
            d_exc     <= 1'b0;
            d_exccode <= 5'd0;
        end
    end
`else
    assign d_exc     = 1'b0;
    assign d_exccode = 5'd0;
`endif

endmodule
